// File: rtl/light_pkg.sv
// Shared tail-light constants: brightness level codes, dimming steps
// and the duty-to-level threshold map used by generators and decoders.
package light_pkg;

  localparam logic [2:0] LVL_OFF  = 3'd0;
  localparam logic [2:0] LVL_DIM  = 3'd1;
  localparam logic [2:0] LVL_LOW  = 3'd2;
  localparam logic [2:0] LVL_MID  = 3'd3;
  localparam logic [2:0] LVL_FULL = 3'd4;

  localparam int unsigned THR_DIM  = 2;
  localparam int unsigned THR_LOW  = 9;
  localparam int unsigned THR_MID  = 39;
  localparam int unsigned THR_FULL = 159;

  localparam logic [7:0] STEP_OFF  = 8'h00;
  localparam logic [7:0] STEP_DIM  = 8'h03;
  localparam logic [7:0] STEP_LOW  = 8'h0F;
  localparam logic [7:0] STEP_MID  = 8'h3F;
  localparam logic [7:0] STEP_FULL = 8'hFF;

  // Thresholds are written for an 8-bit period; rescale by shifting.
  function automatic int unsigned thr_scale(
    input int unsigned base,
    input int          bits
  );
    if (bits >= 8) return base << (bits - 8);
    return base >> (8 - bits);
  endfunction

  function automatic logic [2:0] duty_level(
    input int unsigned d,
    input int          bits
  );
    int unsigned t0;
    int unsigned t1;
    int unsigned t2;
    int unsigned t3;
    logic [2:0]  lv;
    t0 = thr_scale(THR_DIM, bits);
    t1 = thr_scale(THR_LOW, bits);
    t2 = thr_scale(THR_MID, bits);
    t3 = thr_scale(THR_FULL, bits);
    lv = LVL_FULL;
    unique case (1'b1)
      (d < t0):             lv = LVL_OFF;
      (d >= t0 && d < t1):  lv = LVL_DIM;
      (d >= t1 && d < t2):  lv = LVL_LOW;
      (d >= t2 && d < t3):  lv = LVL_MID;
      default:              lv = LVL_FULL;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Bundle between a PWM line under test and its duty decoder:
// the measured line plus the decoded duty/level/valid/locked results.
interface pwm_duty_decoder_if #(
  parameter int PERIOD_BITS = 8
);

  logic                   pwm_in;
  logic [PERIOD_BITS-1:0] duty;
  logic [2:0]             level;
  logic                   valid;
  logic                   locked;

  modport master (
    output pwm_in,
    input  duty,
    input  level,
    input  valid,
    input  locked
  );

  modport slave (
    input  pwm_in,
    output duty,
    output level,
    output valid,
    output locked
  );

endinterface

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser with synchronous clear,
// shared by PWM read-back and push-button inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sh_q[STAGES-1];

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time of one PWM line over rise-aligned windows of
// 2^PERIOD_BITS cycles; static lines are reported by a hunt timeout.
module pwm_duty_decoder
  import light_pkg::*;
#(
  parameter int PERIOD_BITS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  pwm_duty_decoder_if.slave bus
);

  localparam int N = PERIOD_BITS;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_MEAS = 1'b1;

  localparam logic [N-1:0] WLAST = '1;

  logic         s;
  logic         s_d_q;
  logic         rise;
  logic [0:0]   state_q, state_d;
  logic [N-1:0] wcnt_q, wcnt_d;
  logic [N:0]   hcnt_q, hcnt_d;
  logic [N:0]   hsum;
  logic         norise_q, norise_d;
  logic [N-1:0] duty_q, duty_d;
  logic [2:0]   level_q, level_d;
  logic         valid_q, valid_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.pwm_in),
    .q_o   (s)
  );

  assign rise = s & ~s_d_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q + N'(1);
    hcnt_d   = hcnt_q;
    norise_d = norise_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    // wcnt==0 in MEAS is the first cycle of a follow-on window
    hsum = (wcnt_q == '0) ? (N+1)'(s)
                          : hcnt_q + (N+1)'(s);
    unique case (state_q)
      ST_HUNT: begin
        if (rise) begin
          state_d  = ST_MEAS;
          wcnt_d   = N'(1);
          hcnt_d   = (N+1)'(1);
          norise_d = 1'b0;
        end else if (wcnt_q == WLAST) begin
          valid_d = 1'b1;
          duty_d  = s ? '1 : '0;
        end
      end
      default: begin
        hcnt_d = hsum;
        if (wcnt_q == '0) begin
          norise_d = ~rise;
        end
        if (wcnt_q == WLAST) begin
          valid_d = 1'b1;
          duty_d  = hsum[N] ? '1 : hsum[N-1:0];
          if (norise_d) begin
            state_d = ST_HUNT;
          end
        end
      end
    endcase
    level_d = duty_level(32'(duty_d), N);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_d_q    <= 1'b0;
      state_q  <= ST_HUNT;
      wcnt_q   <= '0;
      hcnt_q   <= '0;
      norise_q <= 1'b0;
      duty_q   <= '0;
      level_q  <= LVL_OFF;
      valid_q  <= 1'b0;
    end else begin
      s_d_q    <= s;
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      hcnt_q   <= hcnt_d;
      norise_q <= norise_d;
      duty_q   <= duty_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.duty   = duty_q;
  assign bus.level  = level_q;
  assign bus.valid  = valid_q;
  assign bus.locked = (state_q == ST_MEAS);

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: a free-running PWM generator drives the
// line; each valid is queued and matched against expected windows.
module tb_pwm_duty_decoder;

  localparam int N = 8;
  localparam int W = 256;

  typedef struct {
    logic [7:0] duty;
    logic [2:0] level;
    logic       locked;
    longint     cyc;
  } rec_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  int     checks = 0;
  int     errors = 0;
  int     gen_high = 0;
  int     phase = 0;
  longint cyc = 0;
  rec_t   obs_q[$];
  rec_t   exp_q[$];

  pwm_duty_decoder_if #(.PERIOD_BITS(N)) ifc ();

  pwm_duty_decoder #(
    .PERIOD_BITS (N),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    ifc.pwm_in = 1'b0;
    forever begin
      @(negedge clk);
      ifc.pwm_in = (phase < gen_high);
      phase = (phase + 1) % W;
    end
  end

  always @(negedge clk) begin
    rec_t r;
    cyc++;
    if (ifc.valid === 1'b1) begin
      r.duty   = ifc.duty;
      r.level  = ifc.level;
      r.locked = ifc.locked;
      r.cyc    = cyc;
      obs_q.push_back(r);
    end
  end

  function automatic int exp_level(input int d);
    if (d < 2)   return 0;
    if (d < 9)   return 1;
    if (d < 39)  return 2;
    if (d < 159) return 3;
    return 4;
  endfunction

  task automatic align();
    do @(posedge clk); while (phase != 0);
  endtask

  task automatic run_window(input int high, input int settle, input int m);
    align();
    gen_high = high;
    repeat (settle * W + 8) @(posedge clk);
    obs_q.delete();
    repeat (m * W) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ifc.duty !== 8'd0) begin
      errors++;
      $display("FAIL reset_duty: got %0d want 0", ifc.duty);
    end
    checks++;
    if (ifc.level !== 3'd0) begin
      errors++;
      $display("FAIL reset_level: got %0d want 0", ifc.level);
    end
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", ifc.valid);
    end
    checks++;
    if (ifc.locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_locked: got %b want 0", ifc.locked);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pwm(input string name, input int high,
                          input int settle, input int m,
                          input logic exp_lock);
    rec_t e;
    rec_t o;
    int   ed;
    ed = (high > 255) ? 255 : high;
    for (int i = 0; i < m; i++) begin
      e.duty   = 8'(ed);
      e.level  = 3'(exp_level(ed));
      e.locked = exp_lock;
      e.cyc    = 0;
      exp_q.push_back(e);
    end
    run_window(high, settle, m);
    checks++;
    if (obs_q.size() != m) begin
      errors++;
      $display("FAIL %s count: got %0d valids want %0d",
               name, obs_q.size(), m);
    end
    for (int i = 1; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc - obs_q[i-1].cyc != W) begin
        errors++;
        $display("FAIL %s spacing: got %0d want %0d", name,
                 obs_q[i].cyc - obs_q[i-1].cyc, W);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.duty !== e.duty || o.level !== e.level ||
          o.locked !== e.locked) begin
        errors++;
        $display("FAIL %s result: got duty=%0d level=%0d locked=%b want duty=%0d level=%0d locked=%b",
                 name, o.duty, o.level, o.locked,
                 e.duty, e.level, e.locked);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_first_rise();
    align();
    #1;
    checks++;
    if (ifc.locked !== 1'b0) begin
      errors++;
      $display("FAIL prelock_locked: got %b want 0", ifc.locked);
    end
    gen_high = 3;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (ifc.locked !== 1'b1) begin
      errors++;
      $display("FAIL first_rise_locked: got %b want 1", ifc.locked);
    end
  endtask

  task automatic test_reset_mid_measure();
    align();
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    obs_q.delete();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ifc.duty !== 8'd0 || ifc.level !== 3'd0 ||
        ifc.locked !== 1'b0 || ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got duty=%0d level=%0d locked=%b valid=%b want 0 0 0 0",
               ifc.duty, ifc.level, ifc.locked, ifc.valid);
    end
    align();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_novalid: got %0d valids want 0", obs_q.size());
    end
    checks++;
    if (ifc.locked !== 1'b1) begin
      errors++;
      $display("FAIL midreset_relock: got %b want 1", ifc.locked);
    end
    obs_q.delete();
    repeat (W) @(posedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_window: got %0d valids want 1", obs_q.size());
    end else if (obs_q[0].duty !== 8'd3 || obs_q[0].level !== 3'd1) begin
      errors++;
      $display("FAIL midreset_window: got duty=%0d level=%0d want duty=3 level=1",
               obs_q[0].duty, obs_q[0].level);
    end
    obs_q.delete();
  endtask

  task automatic test_thresholds();
    int hv[8] = '{1, 2, 8, 9, 38, 39, 158, 159};
    foreach (hv[i]) begin
      test_pwm($sformatf("thr_%0d", hv[i]), hv[i], 1, 1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_pwm("static_low", 0, 3, 3, 1'b0);
    test_first_rise();
    test_pwm("duty03", 3, 0, 4, 1'b1);
    test_reset_mid_measure();
    test_pwm("duty3f", 63, 1, 2, 1'b1);
    test_pwm("step0f", 15, 0, 1, 1'b1);
    test_thresholds();
    test_pwm("static_high", 256, 3, 2, 1'b0);
    test_pwm("dutyff", 255, 3, 2, 1'b1);
    test_pwm("sat_full_window", 256, 0, 1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the tail-light PWM generators: measures the duty cycle of one incoming PWM line.
- Reports an 8-bit duty value plus a quantised brightness level (0..4) matching the dimming steps 0x00/0x03/0x0F/0x3F/0xFF.
- Used for loop-back self-test of light channels and for reading back lamp-driver PWM lines.
- Operates in the same clock domain as the PWM generators; the input line is treated as asynchronous.

Parameters:
- PERIOD_BITS, 8, log2 of PWM period in clk cycles; the window is 2^PERIOD_BITS cycles.
- SYNC_STAGES, 2, number of synchroniser flops on pwm_in (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  1  PWM line under measurement (asynchronous).
- duty  out  PERIOD_BITS  last measured high-cycle count, saturated to 2^PERIOD_BITS-1.
- level  out  3  brightness class of duty, 0..4.
- valid  out  1  one-cycle pulse when duty/level update.
- locked  out  1  high while windows are aligned to a rising edge.

Behaviour:
- Reset (sync, active-high) state:
  - duty=0, level=0, valid=0, locked=0.
  - Synchroniser flops cleared to 0; FSM in HUNT; counters 0.
  - Reset asserted mid-window discards the partial measurement; no valid is emitted.
- Input path:
  - pwm_in passes through SYNC_STAGES flops; s = synchronised value.
  - Rising edge is rise = s & ~s_d (one extra flop).
  - All measurement uses s.
- HUNT state:
  - wcnt increments each cycle.
  - On rise: go to MEASURE, wcnt=1, hcnt=1, since the edge cycle counts as high.
  - If wcnt reaches 2^N-1 with no rise: the line is static. Emit valid, set duty = s ? 2^N-1 : 0, reset wcnt to 0, stay in HUNT. This is how 0% and 100% are reported.
- MEASURE state:
  - locked=1.
  - Each cycle: wcnt+=1, hcnt+=s.
  - hcnt is N+1 bits wide; duty = min(hcnt, 2^N-1).
  - When the window has spanned 2^N cycles (wcnt wraps to 0): latch duty/level, pulse valid, start the next window the same cycle with hcnt = s, wcnt = 1.
  - A rise mid-window is ignored, so the window stays phase-held.
  - If a window sees no rise at its first cycle (s was already high, or the line stopped toggling): finish the window normally, then return to HUNT with locked=0.
- Latency:
  - valid occurs 2^N cycles after the locking edge reaches s.
  - pwm_in to s adds SYNC_STAGES cycles.
- Level thresholds (combinational from the saturated duty, registered with duty):
  - duty<2 -> 0
  - duty<9 -> 1
  - duty<39 -> 2
  - duty<159 -> 3
  - otherwise -> 4
- Simultaneous events:
  - Window end and rise in the same cycle: the rise opens the new window; no double count.
  - Reset wins over all events.
- duty, level and locked are registered; valid is registered and lasts exactly 1 cycle.

Decomposition:
- Shared package light_pkg:
  - Level codes LVL_OFF..LVL_FULL (3 bits).
  - Threshold constants 2, 9, 39, 159 (expressed for PERIOD_BITS=8; scaled by shift for other widths).
  - Dimming step constants 0x00, 0x03, 0x0F, 0x3F, 0xFF, also used by the generator side.
- Sub-module sync_ff #(STAGES): generic synchroniser with sync reset, reusable for the left/right button inputs.
- The FSM, counters and level map stay in pwm_duty_decoder (about 150-200 lines).

Test Plan:
- Reset mid-measure: reset for 1 cycle at window cycle 100 -> no valid; duty=0, level=0, locked=0 the next cycle; relock on the next rise.
- Generator duty 0x03, N=8:
  - The first rise locks.
  - Each later window gives valid with duty=3, level=1, every 256 cycles.
  - Successive valids are spaced exactly 256 cycles.
- Generator duty 0x3F -> duty=63, level=3. Step the generator to 0x0F mid-run -> the next full window reports duty=15, level=2.
- Static low line (duty 0x00) -> HUNT timeout every 256 cycles with duty=0, level=0, locked=0. Static high line -> duty=255, level=4.
- Generator 0xFF (255 of 256 high) -> locks on the single rise per period; duty=255, level=4.
  - Variant: hold the line high for a full window -> hcnt=256 saturates to duty=255.
- Threshold edges: drive high counts 1, 2, 8, 9, 38, 39, 158, 159 -> levels 0, 1, 1, 2, 2, 3, 3, 4.
